// File: rtl/my_mux8way_rr.sv
// 8-way round-robin arbitrating mux with a one-word registered output stage.
// Optional transfer counter (out_count) enabled by defining MY_MUX8WAY_RR_CNT_EN.

module my_mux8way_rr_lane #(
   parameter int WIDTH = 1
) (
   input  logic             gnt,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] masked
);
   assign masked = data & {WIDTH{gnt}};
endmodule

module my_mux8way_rr #(
   parameter int WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         in_valid,
   input  logic [8*WIDTH-1:0] in_data,
   output logic [7:0]         in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
`ifdef MY_MUX8WAY_RR_CNT_EN
   output logic [15:0]        out_count,
`endif
   output logic [2:0]         out_sel
);

   logic [2:0]                  ptr;
   logic [2:0]                  gnt_idx;
   logic [7:0]                  gnt_oh;
   logic                        load;
   logic [7:0][WIDTH-1:0]       lane_data;
   logic [WIDTH-1:0]            gnt_data;

   // Search ptr+1 .. ptr+8; k=8 wraps back onto ptr itself.
   always_comb begin
      logic       found;
      logic [2:0] idx;
      found   = 1'b0;
      gnt_idx = 3'd0;
      idx     = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         idx = 3'(ptr + 3'(k));
         if (!found && in_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign load     = (!out_valid || out_ready) && (|in_valid) && !rst;
   assign gnt_oh   = 8'b1 << gnt_idx;
   assign in_ready = load ? gnt_oh : 8'h00;

   genvar i;
   generate
      for (i = 0; i < 8; i++) begin : g_lane
         my_mux8way_rr_lane #(.WIDTH(WIDTH)) u_lane (
            .gnt    (gnt_oh[i]),
            .data   (in_data[i*WIDTH +: WIDTH]),
            .masked (lane_data[i])
         );
      end
   endgenerate

   always_comb begin
      gnt_data = '0;
      for (int j = 0; j < 8; j++) gnt_data = gnt_data | lane_data[j];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= 3'd0;
         ptr       <= 3'd7;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= gnt_data;
         out_sel   <= gnt_idx;
         ptr       <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef MY_MUX8WAY_RR_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)                         out_count <= 16'h0000;
      else if (out_valid && out_ready) out_count <= out_count + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_my_mux8way_rr.sv
// Directed bench for my_mux8way_rr (WIDTH=4); counter checks run when MY_MUX8WAY_RR_CNT_EN is defined.

module tb_my_mux8way_rr;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [7:0]     in_valid;
   logic [8*W-1:0] in_data;
   logic [7:0]     in_ready;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic [2:0]     out_sel;
`ifdef MY_MUX8WAY_RR_CNT_EN
   logic [15:0]    out_count;
`endif

   int n_run  = 0;
   int n_fail = 0;

   my_mux8way_rr #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef MY_MUX8WAY_RR_CNT_EN
      .out_count (out_count),
`endif
      .out_sel   (out_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) in_data[c*W +: W] = W'(c);
      #1;

      // reset held 2 cycles with every channel requesting
      for (int r = 0; r < 2; r++) begin
         tick();
         chk("rst_in_ready", 32'(in_ready), 32'h00);
         chk("rst_out_valid", 32'(out_valid), 32'h0);
      end
      chk("rst_out_sel", 32'(out_sel), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      rst = 1'b0;
      #1;
      chk("first_grant", 32'(in_ready), 32'h01);

      // fairness sweep 0..7,0 at one word per cycle
      for (int k = 0; k < 9; k++) begin
         tick();
         chk("fair_valid", 32'(out_valid), 32'h1);
         chk("fair_sel", 32'(out_sel), 32'(k % 8));
         chk("fair_data", 32'(out_data), 32'(k % 8));
      end

      // backpressure: ptr=0, load channel 2 then stall
      in_valid = 8'h24;
      #1;
      chk("bp_grant2", 32'(in_ready), 32'h04);
      tick();
      chk("bp_sel2", 32'(out_sel), 32'h2);
      out_ready = 1'b0;
      #1;
      for (int s = 0; s < 5; s++) begin
         chk("bp_in_ready", 32'(in_ready), 32'h00);
         tick();
         chk("bp_hold_sel", 32'(out_sel), 32'h2);
         chk("bp_hold_valid", 32'(out_valid), 32'h1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_next5", 32'(in_ready), 32'h20);
      tick();
      chk("bp_sel5", 32'(out_sel), 32'h5);
      chk("bp_next2", 32'(in_ready), 32'h04);
      tick();
      chk("bp_sel2b", 32'(out_sel), 32'h2);

      // wrap: park ptr at 7, then 0x81 grants 0 before 7
      in_valid = 8'h80;
      tick();
      chk("wrap_sel7", 32'(out_sel), 32'h7);
      in_valid = 8'h81;
      #1;
      chk("wrap_grant0", 32'(in_ready), 32'h01);
      tick();
      chk("wrap_sel0", 32'(out_sel), 32'h0);
      chk("wrap_grant7", 32'(in_ready), 32'h80);
      tick();
      chk("wrap_sel7b", 32'(out_sel), 32'h7);

      // sparse single pulse on channel 3 carrying 1
      in_valid = 8'h08;
      in_data[3*W +: W] = W'(1);
      #1;
      chk("sparse_ready", 32'(in_ready), 32'h08);
      tick();
      in_valid = 8'h00;
      #1;
      chk("sparse_valid", 32'(out_valid), 32'h1);
      chk("sparse_sel", 32'(out_sel), 32'h3);
      chk("sparse_data", 32'(out_data), 32'h1);
      chk("sparse_no_ready", 32'(in_ready), 32'h00);
      tick();
      chk("drain_valid", 32'(out_valid), 32'h0);
      chk("drain_sel_hold", 32'(out_sel), 32'h3);
      chk("drain_data_hold", 32'(out_data), 32'h1);

      // reset mid-operation: held word discarded, ptr back to 7
      in_valid  = 8'hFF;
      out_ready = 1'b0;
      tick();
      chk("mid_load_sel", 32'(out_sel), 32'h4);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_sel", 32'(out_sel), 32'h0);
      chk("mid_rst_data", 32'(out_data), 32'h0);
      rst       = 1'b0;
      in_valid  = 8'h42;
      out_ready = 1'b1;
      #1;
      chk("post_rst_grant", 32'(in_ready), 32'h02);
      tick();
      chk("post_rst_sel", 32'(out_sel), 32'h1);
      in_valid = 8'h00;
      tick();

`ifdef MY_MUX8WAY_RR_CNT_EN
      rst = 1'b1;
      tick();
      chk("cnt_rst", 32'(out_count), 32'h0);
      rst      = 1'b0;
      in_valid = 8'h01;
      // first edge only loads; each later edge is one transfer
      for (int e = 0; e < 65536; e++) @(posedge clk);
      #1;
      chk("cnt_max", 32'(out_count), 32'hFFFF);
      tick();
      chk("cnt_wrap", 32'(out_count), 32'h0000);
      tick();
      chk("cnt_one", 32'(out_count), 32'h0001);
      rst = 1'b1;
      tick();
      chk("cnt_mid_rst", 32'(out_count), 32'h0000);
      rst      = 1'b0;
      in_valid = 8'h00;
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/my_mux8way_rr.md
MY_MUX8WAY_RR -- requirements
Module: my_mux8way_rr

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 1, payload bit width per channel (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 8 bits: bit i high means channel i offers a word.
REQ-005 The block SHALL have port in_data, input, 8*WIDTH bits: channel i payload in bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port in_ready, output, 8 bits: bit i high means channel i's word is taken this cycle.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the output register holds a word.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream sink accepts the word this cycle.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: the registered payload.
REQ-010 The block SHALL have port out_sel, output, 3 bits: the registered source channel index, in the same encoding a downstream my_dmux8way sel uses.

Function
REQ-011 An input transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both high at a rising clk edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-012 load = (!out_valid | out_ready) & (|in_valid) SHALL be the sole condition for capturing a new word.
REQ-013 Round-robin pointer ptr[2:0]: the grant SHALL go to the first channel with in_valid set, searching ptr+1, ptr+2, ... ptr+8 modulo 8.
REQ-014 in_ready SHALL be one-hot on the granted channel when load is high and SHALL be all-zero otherwise; it SHALL depend combinationally on in_valid, out_valid, out_ready and ptr only.
REQ-015 On load: out_data <= granted payload, out_sel <= granted index, out_valid <= 1, ptr <= granted index.
REQ-016 On an output transfer without load: out_valid <= 0, and out_data and out_sel SHALL hold their values.
REQ-017 Simultaneous output transfer and load SHALL replace the register contents in the same cycle, giving full throughput of one word per cycle.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_sel and ptr SHALL hold, and in_ready SHALL be 0.
REQ-019 Latency SHALL be 1 cycle from input transfer to out_valid.
REQ-020 ptr SHALL advance only on load, so no channel with in_valid held high waits more than 7 grants.
REQ-021 ptr wrap-around: with ptr=7, the search SHALL begin at channel 0.
REQ-022 The block SHALL neither drop nor duplicate words.
REQ-023 in_valid deasserted without a transfer SHALL be tolerated; no grant SHALL be latched across cycles.

Reset
REQ-024 When rst=1 at a clk edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 7 (channel 0 has first priority).
REQ-025 in_ready SHALL be all-zero while rst=1.
REQ-026 Reset mid-operation SHALL discard the held word, and the first grant after reset SHALL follow the REQ-024 pointer.

Configuration
REQ-027 The macro MY_MUX8WAY_RR_CNT_EN SHALL control one optional feature, a transfer counter.
REQ-028 With MY_MUX8WAY_RR_CNT_EN defined: output port out_count, 16 bits, SHALL increment by 1 on every output transfer, wrap 0xFFFF->0x0000, and reset to 0.
REQ-029 Without MY_MUX8WAY_RR_CNT_EN: out_count SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset check: drive rst=1 for 2 cycles with all in_valid=0xFF -> in_ready=0x00 and out_valid=0 during reset; the first cycle after reset grants channel 0 (in_ready=0x01).
REQ-031 Fairness: WIDTH=4, in_valid=0xFF, channel i data=i, out_ready=1 -> out_sel sequence 0,1,...,7,0; out_data equals out_sel; one word per cycle.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles with in_valid=0x24 -> out_sel=2 held stable and in_ready=0; after release, next grant is channel 5, then 2.
REQ-033 Wrap: ptr=7 and in_valid=0x81 -> grant channel 0, then channel 7.
REQ-034 Sparse traffic: a single pulse on in_valid[3] with data=1 -> in_ready[3]=1 that cycle; out_valid=1 with out_sel=3 and out_data=1 the next cycle; out_valid=0 after drain.
REQ-035 With MY_MUX8WAY_RR_CNT_EN defined: preload 65535 transfers, then 1 more -> out_count=0x0000; rst mid-stream -> out_count=0.
